// File: rtl/alu_logic_pkg.sv
// Shared opcode, FSM-state and expected-result definitions for the logic ALU checker.
// Purely declarative: no registers live here.
// The expected-result function is also meant for reuse by stimulus benches.
package alu_logic_pkg;

  // Widest operand the expected-result function handles; callers cast down.
  localparam int ALU_MAX_W = 32;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Expected result of one logic op; the reserved opcode yields zero.
  function automatic logic [ALU_MAX_W-1:0] alu_expected(
    input logic [ALU_MAX_W-1:0] a,
    input logic [ALU_MAX_W-1:0] b,
    input logic [2:0]           op
  );
    logic [ALU_MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOTA: r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_logic_ref.sv
// Combinational expected-result model for the WIDTH-bit logic ALU.
// Latency: zero cycles (pure combinational).
// No handshake; output follows inputs.
module alu_logic_ref
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] exp_o
);

  // Evaluate at full function width; upper bits (e.g. from NOT) are dropped.
  assign exp_o = WIDTH'(alu_expected(ALU_MAX_W'(a_i), ALU_MAX_W'(b_i), op_i));

endmodule

// File: rtl/alu_logic_checker.sv
// Response checker for logic ALU units: computes expected results, tallies pass/fail, captures first mismatch.
// Latency: 2 stages; a vector accepted at edge N shows in the counters after edge N+1.
// Backpressure: in_ready high only in RUN; in_valid is ignored otherwise, nothing is buffered.
module alu_logic_checker
  import alu_logic_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dut_out,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic [2:0]       err_op,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_a_q, err_a_d, err_b_q, err_b_d;
  logic [2:0]       err_op_q, err_op_d;
  logic [WIDTH-1:0] err_exp_q, err_exp_d, err_got_q, err_got_d;

  // Stage-1 registers
  logic             s1_vld_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_got_q;
  logic [2:0]       s1_op_q;

  logic             accept;
  logic [WIDTH-1:0] exp_val;
  logic             cmp_bad;

  assign accept = in_valid && (state_q == ST_RUN);

  alu_logic_ref #(.WIDTH(WIDTH)) u_ref (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .op_i  (s1_op_q),
    .exp_o (exp_val)
  );

  // Reserved opcode fails regardless of what the unit produced.
  assign cmp_bad = (s1_op_q == OP_RSVD) || (exp_val != s1_got_q);

  // Next-state: run FSM, stage-2 tally with saturation, first-mismatch capture.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    err_d     = err_q;
    err_a_d   = err_a_q;
    err_b_d   = err_b_q;
    err_op_d  = err_op_q;
    err_exp_d = err_exp_q;
    err_got_d = err_got_q;

    if (s1_vld_q) begin
      if (cmp_bad) begin
        if (fail_q != {CNT_W{1'b1}}) fail_d = fail_q + CNT_W'(1);
        if (!err_q) begin
          err_d     = 1'b1;
          err_a_d   = s1_a_q;
          err_b_d   = s1_b_q;
          err_op_d  = s1_op_q;
          err_exp_d = exp_val;
          err_got_d = s1_got_q;
        end
      end else if (pass_q != {CNT_W{1'b1}}) begin
        pass_d = pass_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Stage 1 is empty here, so the clears cannot collide with a tally.
        if (start) begin
          state_d   = ST_RUN;
          acc_d     = '0;
          pass_d    = '0;
          fail_d    = '0;
          err_d     = 1'b0;
          err_a_d   = '0;
          err_b_d   = '0;
          err_op_d  = '0;
          err_exp_d = '0;
          err_got_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_d = acc_q + CNT_W'(1);
          if (acc_d == CNT_W'(NUM_VECTORS)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave only once the last vector's tally has landed, so done lags it by a cycle.
        if (!s1_vld_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and tally state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      err_q     <= 1'b0;
      err_a_q   <= '0;
      err_b_q   <= '0;
      err_op_q  <= '0;
      err_exp_q <= '0;
      err_got_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
      err_a_q   <= err_a_d;
      err_b_q   <= err_b_d;
      err_op_q  <= err_op_d;
      err_exp_q <= err_exp_d;
      err_got_q <= err_got_d;
    end
  end

  // Stage-1 capture of the accepted vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_op_q  <= '0;
      s1_got_q <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_a_q   <= a;
        s1_b_q   <= b;
        s1_op_q  <= op;
        s1_got_q <= dut_out;
      end
    end
  end

  assign in_ready   = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign err        = err_q;
  assign err_a      = err_a_q;
  assign err_b      = err_b_q;
  assign err_op     = err_op_q;
  assign err_exp    = err_exp_q;
  assign err_got    = err_got_q;

endmodule
